red_streak_locator: RTL

- Consumer of the filtered 1-bit white_pixel stream produced by the red low-pass filter stage.
- Scans each raster line for runs of consecutive white pixels and tracks the longest run seen in the frame.
- At end of frame, publishes that run's centre column, line and width as the ball position for the flipdot output path.
- Sits alongside the frame-buffer writer on the same VGA_clock pixel stream and uses the same x_cont, y_cont, h_sync and v_sync.

---
 rtl/red_streak_locator.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/red_streak_locator.sv
// rtl/red_streak_locator.sv - longest white run per frame -> ball centre/line/width; macro STREAK_DEBUG_EN adds debug_io
module red_streak_locator #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int MIN_RUN  = 4,
  parameter int Y_OFFSET = 2
) (
  input  logic       VGA_clock,
  input  logic       reset,
  input  logic       white_pixel,
  input  logic [9:0] x_cont,
  input  logic [8:0] y_cont,
  input  logic       h_sync,
  input  logic       v_sync,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [9:0] ball_width,
  output logic       ball_valid,
  output logic       frame_done
`ifdef STREAK_DEBUG_EN
  ,
  output logic [6:0] debug_io
`endif
);

  localparam logic [9:0] LP_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] LP_H_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [8:0] LP_V_ACTIVE = 9'(V_ACTIVE);
  localparam logic [9:0] LP_MIN_RUN  = 10'(MIN_RUN);
  localparam logic [8:0] LP_Y_OFFSET = 9'(Y_OFFSET);

  typedef enum logic [1:0] {
    START_UP = 2'd0,
    WAIT     = 2'd1,
    IS_RED   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [9:0] r_cntr;
  logic [9:0] w_cntr_nxt;
  logic [9:0] w_cntr_inc;

  logic       r_hs_prev;
  logic       r_vs_prev;
  logic       w_hs_fall;
  logic       w_vs_fall;
  logic       w_active;

  // Run closure candidate produced by the scanner this cycle
  logic       w_close;
  logic [9:0] w_close_len;
  logic [9:0] w_close_end;

  // Frame-best tracking
  logic [9:0] r_max_ever;
  logic [9:0] r_end_x;
  logic [8:0] r_line_of_max;
  logic       w_better;
  logic [9:0] w_max_eff;
  logic [9:0] w_end_eff;
  logic [8:0] w_line_eff;
  logic [9:0] w_ball_x_new;
  logic [8:0] w_ball_y_new;

  // Published results
  logic [9:0] r_ball_x;
  logic [8:0] r_ball_y;
  logic [9:0] r_ball_width;
  logic       r_ball_valid;
  logic       r_frame_done;

  assign w_hs_fall = r_hs_prev & ~h_sync;
  assign w_vs_fall = r_vs_prev & ~v_sync;
  assign w_active  = (x_cont < LP_H_ACTIVE) && (y_cont < LP_V_ACTIVE);

  // Run counter saturates at a full line width
  assign w_cntr_inc = (r_cntr >= LP_H_ACTIVE) ? LP_H_ACTIVE : (r_cntr + 10'd1);

  // Previous-sample registers for sync edge detection; idle level is high
  always_ff @(posedge VGA_clock or negedge reset) begin
    if (!reset) begin
      r_hs_prev <= 1'b1;
      r_vs_prev <= 1'b1;
    end else begin
      r_hs_prev <= h_sync;
      r_vs_prev <= v_sync;
    end
  end

  // FSM state and run counter registers
  always_ff @(posedge VGA_clock or negedge reset) begin
    if (!reset) begin
      r_state <= START_UP;
      r_cntr  <= 10'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cntr  <= w_cntr_nxt;
    end
  end

  // Next-state logic: run start, extension and closure; syncs override last
  always_comb begin
    w_state_nxt = r_state;
    w_cntr_nxt  = r_cntr;
    w_close     = 1'b0;
    w_close_len = r_cntr;
    w_close_end = x_cont - 10'd1;
    case (r_state)
      START_UP: begin
        w_state_nxt = START_UP;
      end
      WAIT: begin
        if (w_active && white_pixel) begin
          if (x_cont == LP_H_LAST) begin
            // single-pixel run on the last column closes immediately
            w_close     = 1'b1;
            w_close_len = 10'd1;
            w_close_end = LP_H_LAST;
            w_cntr_nxt  = 10'd1;
          end else begin
            w_cntr_nxt  = 10'd1;
            w_state_nxt = IS_RED;
          end
        end
      end
      IS_RED: begin
        if (w_active) begin
          if (!white_pixel) begin
            w_close     = 1'b1;
            w_close_len = r_cntr;
            w_close_end = x_cont - 10'd1;
            w_state_nxt = WAIT;
          end else if (x_cont == LP_H_LAST) begin
            // a run never wraps onto the next line
            w_close     = 1'b1;
            w_close_len = w_cntr_inc;
            w_close_end = LP_H_LAST;
            w_cntr_nxt  = w_cntr_inc;
            w_state_nxt = WAIT;
          end else begin
            w_cntr_nxt  = w_cntr_inc;
          end
        end
      end
      default: begin
        w_state_nxt = START_UP;
      end
    endcase
    if (w_hs_fall && (r_state != START_UP)) begin
      w_state_nxt = WAIT;
    end
    if (w_vs_fall) begin
      w_state_nxt = WAIT;
      w_cntr_nxt  = 10'd0;
    end
  end

  // Strict compare keeps the earliest run on ties
  always_comb begin
    w_better   = w_close && (w_close_len > r_max_ever);
    w_max_eff  = r_max_ever;
    w_end_eff  = r_end_x;
    w_line_eff = r_line_of_max;
    if (w_better) begin
      w_max_eff  = w_close_len;
      w_end_eff  = w_close_end;
      w_line_eff = y_cont;
    end
  end

  // Result arithmetic from the frame best including any run closing this cycle
  always_comb begin
    w_ball_x_new = w_end_eff - ((w_max_eff - 10'd1) >> 1);
    if (w_line_eff < LP_Y_OFFSET) begin
      w_ball_y_new = 9'd0;
    end else begin
      w_ball_y_new = w_line_eff - LP_Y_OFFSET;
    end
  end

  // Frame-best tracking and end-of-frame publish
  always_ff @(posedge VGA_clock or negedge reset) begin
    if (!reset) begin
      r_max_ever    <= 10'd0;
      r_end_x       <= 10'd0;
      r_line_of_max <= 9'd0;
      r_ball_x      <= 10'd0;
      r_ball_y      <= 9'd0;
      r_ball_width  <= 10'd0;
      r_ball_valid  <= 1'b0;
      r_frame_done  <= 1'b0;
    end else if (w_vs_fall) begin
      r_max_ever    <= 10'd0;
      r_end_x       <= 10'd0;
      r_line_of_max <= 9'd0;
      r_frame_done  <= 1'b0;
      // the first v_sync after reset only arms the locator
      if (r_state != START_UP) begin
        r_frame_done <= 1'b1;
        if (w_max_eff >= LP_MIN_RUN) begin
          r_ball_x     <= w_ball_x_new;
          r_ball_y     <= w_ball_y_new;
          r_ball_width <= w_max_eff;
          r_ball_valid <= 1'b1;
        end else begin
          r_ball_valid <= 1'b0;
        end
      end
    end else begin
      r_frame_done <= 1'b0;
      if (w_better) begin
        r_max_ever    <= w_close_len;
        r_end_x       <= w_close_end;
        r_line_of_max <= y_cont;
      end
    end
  end

  assign ball_x     = r_ball_x;
  assign ball_y     = r_ball_y;
  assign ball_width = r_ball_width;
  assign ball_valid = r_ball_valid;
  assign frame_done = r_frame_done;

`ifdef STREAK_DEBUG_EN
  logic [6:0] r_debug;

  // Registered snapshot of input pixel, FSM state, counter LSBs and syncs
  always_ff @(posedge VGA_clock or negedge reset) begin
    if (!reset) begin
      r_debug <= 7'd0;
    end else begin
      r_debug <= {white_pixel, r_state, r_cntr[1:0], h_sync, v_sync};
    end
  end

  assign debug_io = r_debug;
`endif

endmodule
